// File: rtl/video_color_lut.sv
// Purpose : per-channel colour conversion (resistor curve / replicate / zero-pad /
//           double-buffered user LUT) between the core RGB output and the video path.
// Latency : 2 clocks for colour and timing, fixed; no backpressure, advances every clock.
//
// Ports:
//   i_EMU_MCLK, i_EMU_INITRST      clock, async active-high reset
//   i_MODE                         0 curve, 1 replicate, 2 user LUT, 3 zero-pad
//                                  (sampled at vertical blank start)
//   i_CEN, i_HBLANK .. i_VSYNC     pixel enable and timing, delayed 2 clocks to o_*
//   i_RGB / o_RGB                  packed pixel, channel 0 in the low slice
//   i_LUT_WR/CH/IDX/DATA           write port into the shadow LUT bank
//   i_LUT_COMMIT                   request bank swap at the next vertical blank start
//   o_LUT_PENDING, o_USER_VALID    swap outstanding / at least one swap completed

module video_color_lut #(
  parameter int IN_BITS  = 5,
  parameter int OUT_BITS = 8,
  parameter int CHANNELS = 3,
  parameter int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         i_EMU_MCLK,
  input  logic                         i_EMU_INITRST,
  input  logic [1:0]                   i_MODE,
  input  logic                         i_CEN,
  input  logic                         i_HBLANK,
  input  logic                         i_VBLANK,
  input  logic                         i_HSYNC,
  input  logic                         i_VSYNC,
  input  logic [CHANNELS*IN_BITS-1:0]  i_RGB,
  output logic                         o_CEN,
  output logic                         o_HBLANK,
  output logic                         o_VBLANK,
  output logic                         o_HSYNC,
  output logic                         o_VSYNC,
  output logic [CHANNELS*OUT_BITS-1:0] o_RGB,
  input  logic                         i_LUT_WR,
  input  logic [CH_BITS-1:0]           i_LUT_CH,
  input  logic [IN_BITS-1:0]           i_LUT_IDX,
  input  logic [OUT_BITS-1:0]          i_LUT_DATA,
  input  logic                         i_LUT_COMMIT,
  output logic                         o_LUT_PENDING,
  output logic                         o_USER_VALID
);

  // Each channel RAM holds both banks: bank bit on top of the colour index.
  localparam int DEPTH = 2 * (1 << IN_BITS);
  localparam int AW    = IN_BITS + 1;

  // The resistor-network table only exists for the 5-bit to 8-bit case;
  // everything else falls back to bit replication.
  localparam bit HAS_CURVE = (IN_BITS == 5) && (OUT_BITS == 8);

  // Entry [31] is the first element of the concatenation.
  localparam logic [31:0][7:0] CURVE_TBL = {
    8'hFF, 8'hCC, 8'hA8, 8'h8E, 8'h78, 8'h68, 8'h5B, 8'h50,
    8'h49, 8'h40, 8'h39, 8'h33, 8'h2E, 8'h29, 8'h24, 8'h21,
    8'h1C, 8'h19, 8'h16, 8'h14, 8'h12, 8'h0F, 8'h0D, 8'h0B,
    8'h09, 8'h08, 8'h06, 8'h05, 8'h04, 8'h02, 8'h01, 8'h00
  };

  typedef enum logic [1:0] {
    MODE_CURVE  = 2'd0,
    MODE_LINEAR = 2'd1,
    MODE_USER   = 2'd2,
    MODE_ZERO   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_st_e;

  // ---------------------------------------------------------------------------
  // Conversion helpers
  // ---------------------------------------------------------------------------

  // MSB-first repetition of the input bits until OUT_BITS are filled.
  function automatic logic [OUT_BITS-1:0] replicate(input logic [IN_BITS-1:0] v);
    logic [OUT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      r[OUT_BITS-1-i] = v[IN_BITS-1-(i % IN_BITS)];
    end
    return r;
  endfunction

  function automatic logic [OUT_BITS-1:0] zero_pad(input logic [IN_BITS-1:0] v);
    logic [OUT_BITS-1:0] r;
    r = '0;
    r[OUT_BITS-1 -: IN_BITS] = v;
    return r;
  endfunction

  // Only meaningful when HAS_CURVE; the casts keep it elaborating for any sizes.
  function automatic logic [OUT_BITS-1:0] curve(input logic [IN_BITS-1:0] v);
    logic [4:0] idx;
    idx = 5'(v);
    return OUT_BITS'(CURVE_TBL[idx]);
  endfunction

  // ---------------------------------------------------------------------------
  // Timing / pixel pipeline
  // ---------------------------------------------------------------------------
  logic [CHANNELS*IN_BITS-1:0]  s1_rgb;
  logic                         s1_cen;
  logic                         s1_hblank;
  logic                         s1_vblank;
  logic                         s1_hsync;
  logic                         s1_vsync;
  logic [CHANNELS*OUT_BITS-1:0] rgb_next;
  logic                         vblank_rise;

  // Stage-2 VBLANK doubles as the "previous" sample for edge detection.
  assign vblank_rise = s1_vblank & ~o_VBLANK;

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      s1_rgb    <= '0;
      s1_cen    <= 1'b0;
      s1_hblank <= 1'b0;
      s1_vblank <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      o_CEN     <= 1'b0;
      o_HBLANK  <= 1'b0;
      o_VBLANK  <= 1'b0;
      o_HSYNC   <= 1'b0;
      o_VSYNC   <= 1'b0;
      o_RGB     <= '0;
    end else begin
      s1_rgb    <= i_RGB;
      s1_cen    <= i_CEN;
      s1_hblank <= i_HBLANK;
      s1_vblank <= i_VBLANK;
      s1_hsync  <= i_HSYNC;
      s1_vsync  <= i_VSYNC;
      o_CEN     <= s1_cen;
      o_HBLANK  <= s1_hblank;
      o_VBLANK  <= s1_vblank;
      o_HSYNC   <= s1_hsync;
      o_VSYNC   <= s1_vsync;
      o_RGB     <= (s1_hblank | s1_vblank) ? '0 : rgb_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Mode register: only follows i_MODE at frame boundaries so a mode change
  // never tears a visible frame. The first clock after reset also samples it
  // so the very first frame is not stuck in mode 0.
  // ---------------------------------------------------------------------------
  mode_e mode_q;
  mode_e eff_mode;
  logic  first_clk;

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      mode_q    <= MODE_CURVE;
      first_clk <= 1'b1;
    end else begin
      first_clk <= 1'b0;
      if (first_clk || vblank_rise) begin
        mode_q <= mode_e'(i_MODE);
      end
    end
  end

  // User LUT is garbage until the first swap, so show the curve instead.
  always_comb begin
    eff_mode = mode_q;
    if (eff_mode == MODE_USER && !o_USER_VALID) begin
      eff_mode = MODE_CURVE;
    end
    if (eff_mode == MODE_CURVE && !HAS_CURVE) begin
      eff_mode = MODE_LINEAR;
    end
  end

  // ---------------------------------------------------------------------------
  // Bank swap FSM
  // ---------------------------------------------------------------------------
  swap_st_e state;
  swap_st_e next_state;
  logic     swap;
  logic     active_bank;
  logic     lut_wr_ok;
  logic [AW-1:0] wr_addr;

  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state        <= ST_IDLE;
      active_bank  <= 1'b0;
      o_USER_VALID <= 1'b0;
    end else begin
      state <= next_state;
      if (swap) begin
        active_bank  <= ~active_bank;
        o_USER_VALID <= 1'b1;
      end
    end
  end

  // A commit landing on a VBLANK rise only reaches PENDING on that edge,
  // so the swap naturally waits for the following rise.
  always_comb begin
    next_state = state;
    swap       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_LUT_COMMIT) begin
          next_state = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (vblank_rise) begin
          next_state = ST_IDLE;
          swap       = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign o_LUT_PENDING = (state == ST_PENDING);

  // Writes while a swap is outstanding are dropped: the shadow bank is frozen
  // so the committed contents are exactly what goes live.
  assign lut_wr_ok = i_LUT_WR && (state == ST_IDLE) && (32'(i_LUT_CH) < 32'(CHANNELS));
  assign wr_addr   = {~active_bank, i_LUT_IDX};

  // ---------------------------------------------------------------------------
  // Per-channel LUT RAM and output select
  // ---------------------------------------------------------------------------
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic [OUT_BITS-1:0] ram_q;
    logic [IN_BITS-1:0]  pix;
    logic [OUT_BITS-1:0] conv;

    // Plain RAM: no reset, one write port, one registered read port.
    // The read is issued alongside stage 1 so the data lines up with s1_rgb.
    always_ff @(posedge i_EMU_MCLK) begin
      if (lut_wr_ok && (i_LUT_CH == CH_BITS'(c))) begin
        mem[wr_addr] <= i_LUT_DATA;
      end
      ram_q <= mem[{active_bank, i_RGB[c*IN_BITS +: IN_BITS]}];
    end

    assign pix = s1_rgb[c*IN_BITS +: IN_BITS];

    always_comb begin
      conv = replicate(pix);
      unique case (eff_mode)
        MODE_CURVE:  conv = curve(pix);
        MODE_LINEAR: conv = replicate(pix);
        MODE_USER:   conv = ram_q;
        MODE_ZERO:   conv = zero_pad(pix);
        default:     conv = replicate(pix);
      endcase
    end

    assign rgb_next[c*OUT_BITS +: OUT_BITS] = conv;
  end

endmodule

// File: doc/video_color_lut.md
Name: video_color_lut

Overview:
- Parametrised per-channel colour-conversion pipeline between the game core's N-bit RGB output and the arcade video/scaler path.
- Supports four conversion modes: built-in resistor-network curve, linear bit-replicate, zero-pad, and a runtime-loadable user LUT.
- The user LUT is double-buffered; banks swap only at vertical blank.
- Blank/sync/pixel-enable are delayed to stay aligned with the converted colour.

Parameters:
- IN_BITS, 5, bits per colour channel at the input.
- OUT_BITS, 8, bits per colour channel at the output; must be ≥ IN_BITS.
- CHANNELS, 3, number of colour channels; channel 0 is in the least-significant slice.
- CH_BITS, $clog2(CHANNELS) (min 1), width of the LUT channel select.

Ports:
- i_EMU_MCLK  in  1  core clock.
- i_EMU_INITRST  in  1  asynchronous active-high reset.
- i_MODE  in  2  0 = original curve, 1 = linear replicate, 2 = user LUT, 3 = zero-pad.
- i_CEN  in  1  pixel clock enable.
- i_HBLANK, i_VBLANK, i_HSYNC, i_VSYNC  in  1 each  video timing inputs.
- i_RGB  in  CHANNELS*IN_BITS  input pixel.
- o_CEN, o_HBLANK, o_VBLANK, o_HSYNC, o_VSYNC  out  1 each  timing, delayed by 2 clocks.
- o_RGB  out  CHANNELS*OUT_BITS  converted pixel.
- i_LUT_WR  in  1  write strobe to the shadow bank.
- i_LUT_CH  in  CH_BITS  channel select.
- i_LUT_IDX  in  IN_BITS  LUT entry index.
- i_LUT_DATA  in  OUT_BITS  LUT entry value.
- i_LUT_COMMIT  in  1  single-cycle request to swap banks at the next VBLANK rise.
- o_LUT_PENDING  out  1  commit accepted, swap not yet done.
- o_USER_VALID  out  1  at least one swap has completed.

Behaviour:
- Single clock domain (i_EMU_MCLK). i_EMU_INITRST is asynchronous and active-high.
- Reset values:
  - All outputs 0.
  - Active bank = 0, mode register = 0, FSM = IDLE.
  - LUT RAM contents are not reset; they are undefined until written.
- Pipeline: fixed 2-clock latency, advancing every clock independent of i_CEN. The timing signals and i_CEN pass through the same 2-stage delay.
  - Stage 1 registers the input pixel and presents the synchronous RAM read address {active_bank, i_RGB slice}.
  - Stage 2 selects the result by the registered mode.
- Blank forcing: if stage-2 HBLANK or VBLANK is 1, o_RGB = 0.
- Mode register:
  - Loads i_MODE on the cycle VBLANK rises (detected as stage-1 VBLANK = 1 while previous = 0).
  - Also loads i_MODE on the first clock after reset.
  - Mid-frame changes to i_MODE therefore have no effect.
- Mode 0:
  - For IN_BITS = 5 and OUT_BITS = 8, the fixed table is 00,01,02,04,05,06,08,09,0B,0D,0F,12,14,16,19,1C,21,24,29,2E,33,39,40,49,50,5B,68,78,8E,A8,CC,FF.
  - For any other parameter combination, mode 0 behaves as mode 1.
- Mode 1: MSB-first repetition of the input bits to fill OUT_BITS (5→8: {v, v[4:2]}).
- Mode 3: {v, (OUT_BITS−IN_BITS) zeros}.
- Mode 2:
  - Output is the RAM read from the active bank.
  - If o_USER_VALID = 0, mode 2 behaves as mode 0.
- RAM organisation: one RAM per channel, depth 2·2^IN_BITS, width OUT_BITS, with one write port and one read port.
  - Writes always target the shadow bank (~active).
  - A write with i_LUT_CH ≥ CHANNELS is ignored.
- Swap FSM:
  - IDLE: i_LUT_COMMIT moves to PENDING and sets o_LUT_PENDING = 1.
  - PENDING: i_LUT_WR is ignored (dropped), and a repeated i_LUT_COMMIT has no effect.
  - PENDING → IDLE on the next VBLANK rise. On that transition the active bank toggles, o_USER_VALID is set (sticky until reset), and o_LUT_PENDING clears.
  - If commit and a VBLANK rise occur in the same cycle, the swap waits for the following rise.
  - The new bank takes effect for stage-1 reads from the clock after the swap.
- A reset mid-load or mid-pending returns to IDLE with bank 0 and o_USER_VALID = 0.

Test Plan:
1. Reset release, i_MODE=0, i_RGB={5'd31,5'd16,5'd10}, blanks low → after 2 clocks o_RGB={FF,21,0F}; all outputs were 0 during reset.
2. i_MODE=1 applied, then VBLANK pulse, then i_RGB ch0=16 → 0x84. i_MODE=3 plus a VBLANK pulse, then ch0=16 → 0x80. A mode change without a VBLANK pulse leaves the output unchanged.
3. Write ch0 idx 5 = 0x77, commit, i_MODE=2 → o_LUT_PENDING=1 and the output still follows the mode-0 curve (ch0=5 → 06) until the VBLANK rise. After the rise: o_USER_VALID=1 and ch0=5 → 0x77.
4. While pending, write ch0 idx 5 = 0x11 and send a second commit → after the swap, 0x11 is absent from both banks and pending clears after exactly one swap.
5. Commit coincident with a VBLANK rise → no swap on that rise; the swap occurs on the next rise.
6. i_HBLANK=1 with i_RGB all 31 → o_RGB=0. Each timing output equals its input delayed by exactly 2 clocks. Asserting reset during PENDING → o_LUT_PENDING=0 and o_USER_VALID=0.
